// File: rtl/conv_pkg.sv
// Shared width helpers, coefficient type and identity-kernel generator
// for the multichannel convolution pipe.
package conv_pkg;

   localparam int DEF_KERNEL_WIDTH = 8;

   typedef logic signed [DEF_KERNEL_WIDTH-1:0] coef_t;

   function automatic int prod_width(input int color_w, input int kernel_w);
      return color_w + kernel_w + 1;
   endfunction

   function automatic int acc_width(input int color_w, input int kernel_w, input int kernel);
      return prod_width(color_w, kernel_w) + $clog2(kernel * kernel);
   endfunction

   function automatic int kaddr_width(input int kernel);
      return $clog2(kernel * kernel);
   endfunction

   // Only the centre tap is set, scaled so the normalisation shift cancels it.
   function automatic logic [31:0] identity_coef(input int idx, input int kernel, input int shift);
      if (idx == (kernel * kernel - 1) / 2) begin
         return 32'd1 << shift;
      end else begin
         return 32'd0;
      end
   endfunction

endpackage

// File: rtl/conv_channel_mac.sv
// One colour channel of the convolution pipe: S1 products, S2 sum,
// S3 shift / optional magnitude / clip, all held when i_en is low.
module conv_channel_mac
   import conv_pkg::*;
#(
   parameter int KERNEL            = 3,
   parameter int COLOR_CHANNEL     = 8,
   parameter int DATA_KERNEL_WIDTH = 8,
   parameter int SHIFT             = 0
) (
   input  logic                                          i_clk,
   input  logic                                          i_rst_n,
   input  logic                                          i_en,
   input  logic                                          i_mode,
   input  logic [KERNEL*KERNEL*COLOR_CHANNEL-1:0]        i_samples,
   input  logic [KERNEL*KERNEL*DATA_KERNEL_WIDTH-1:0]    i_coefs,
   output logic [COLOR_CHANNEL-1:0]                      o_pixel
);

   localparam int KK   = KERNEL * KERNEL;
   localparam int CC   = COLOR_CHANNEL;
   localparam int DKW  = DATA_KERNEL_WIDTH;
   localparam int PW   = prod_width(CC, DKW);
   localparam int ACCW = acc_width(CC, DKW, KERNEL);
   localparam logic signed [ACCW-1:0] MAXV = ACCW'((2 ** CC) - 1);

   logic signed [PW-1:0]   w_prod [KK];
   logic signed [PW-1:0]   r_prod [KK];
   logic signed [ACCW-1:0] w_sum;
   logic signed [ACCW-1:0] r_sum;
   logic signed [ACCW-1:0] w_shifted;
   logic signed [ACCW-1:0] w_mag;
   logic [CC-1:0]          w_clip;

   // S1: zero-extended sample times signed coefficient.
   always_comb begin
      for (int k = 0; k < KK; k++) begin
         w_prod[k] = PW'($signed({1'b0, i_samples[k*CC +: CC]})) *
                     PW'($signed(i_coefs[k*DKW +: DKW]));
      end
   end

   // S2: sign-extended sum of all taps.
   always_comb begin
      w_sum = '0;
      for (int k = 0; k < KK; k++) begin
         w_sum = w_sum + ACCW'(r_prod[k]);
      end
   end

   // S3: floor shift, optional magnitude, then saturate into the sample range.
   always_comb begin
      w_shifted = r_sum >>> SHIFT;
      w_mag     = w_shifted;
      w_clip    = '0;
      if (i_mode && w_shifted[ACCW-1]) begin
         w_mag = -w_shifted;
      end else begin
         w_mag = w_shifted;
      end
      if (w_mag[ACCW-1]) begin
         w_clip = '0;
      end else if (w_mag > MAXV) begin
         w_clip = '1;
      end else begin
         w_clip = w_mag[CC-1:0];
      end
   end

   // Stage registers, all advancing together.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < KK; k++) begin
            r_prod[k] <= '0;
         end
         r_sum   <= '0;
         o_pixel <= '0;
      end else if (i_en) begin
         r_prod  <= w_prod;
         r_sum   <= w_sum;
         o_pixel <= w_clip;
      end
   end

endmodule

// File: rtl/conv_multichannel_pipe.sv
// Three-stage back-pressurable KxK convolution over NUM_CHANNELS channels with a
// shared double-buffered kernel, sideband passthrough and valid/ready flow control.
module conv_multichannel_pipe
   import conv_pkg::*;
#(
   parameter int KERNEL            = 3,
   parameter int NUM_CHANNELS      = 3,
   parameter int COLOR_CHANNEL     = 8,
   parameter int DATA_KERNEL_WIDTH = 8,
   parameter int SHIFT             = 0,
   parameter int USER_WIDTH        = 2
) (
   input  logic                                                   i_clk,
   input  logic                                                   i_rst_n,
   input  logic                                                   i_valid,
   output logic                                                   o_ready,
   input  logic [KERNEL*KERNEL*NUM_CHANNELS*COLOR_CHANNEL-1:0]    i_pixel_area_data,
   input  logic [USER_WIDTH-1:0]                                  i_user,
   input  logic                                                   i_mode,
   input  logic                                                   i_kernel_wr_en,
   input  logic [kaddr_width(KERNEL)-1:0]                         i_kernel_wr_addr,
   input  logic signed [DATA_KERNEL_WIDTH-1:0]                    i_kernel_wr_data,
   input  logic                                                   i_kernel_swap,
   output logic                                                   o_valid,
   input  logic                                                   i_ready,
   output logic [NUM_CHANNELS*COLOR_CHANNEL-1:0]                  o_pixel,
   output logic [USER_WIDTH-1:0]                                  o_user
);

   localparam int KK  = KERNEL * KERNEL;
   localparam int AW  = kaddr_width(KERNEL);
   localparam int DKW = DATA_KERNEL_WIDTH;
   localparam int CC  = COLOR_CHANNEL;

   logic                  w_advance;
   logic                  r_v1;
   logic                  r_v2;
   logic                  r_mode1;
   logic                  r_mode2;
   logic [USER_WIDTH-1:0] r_user1;
   logic [USER_WIDTH-1:0] r_user2;
   logic signed [DKW-1:0] r_shadow [KK];
   logic signed [DKW-1:0] r_active [KK];
   logic signed [DKW-1:0] w_shadow_nxt [KK];
   logic [KK*DKW-1:0]     w_coefs;

   assign w_advance = !o_valid || i_ready;
   assign o_ready   = w_advance;

   // Shadow bank with this cycle's write folded in; out-of-range addresses match no tap.
   always_comb begin
      for (int k = 0; k < KK; k++) begin
         if (i_kernel_wr_en && (i_kernel_wr_addr == AW'(k))) begin
            w_shadow_nxt[k] = i_kernel_wr_data;
         end else begin
            w_shadow_nxt[k] = r_shadow[k];
         end
      end
   end

   // Kernel banks; a swap copies the shadow including a same-cycle write.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < KK; k++) begin
            r_shadow[k] <= DKW'(identity_coef(k, KERNEL, SHIFT));
            r_active[k] <= DKW'(identity_coef(k, KERNEL, SHIFT));
         end
      end else begin
         r_shadow <= w_shadow_nxt;
         if (i_kernel_swap) begin
            r_active <= w_shadow_nxt;
         end
      end
   end

   // Stage valids and the mode/sideband pipe that travels with each pixel.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         o_valid <= 1'b0;
         r_mode1 <= 1'b0;
         r_mode2 <= 1'b0;
         r_user1 <= '0;
         r_user2 <= '0;
         o_user  <= '0;
      end else if (w_advance) begin
         r_v1    <= i_valid;
         r_v2    <= r_v1;
         o_valid <= r_v2;
         r_mode1 <= i_mode;
         r_mode2 <= r_mode1;
         r_user1 <= i_user;
         r_user2 <= r_user1;
         o_user  <= r_user2;
      end
   end

   for (genvar g = 0; g < KK; g++) begin : g_coef
      assign w_coefs[g*DKW +: DKW] = r_active[g];
   end

   for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
      logic [KK*CC-1:0] w_samples;

      for (genvar k = 0; k < KK; k++) begin : g_tap
         assign w_samples[k*CC +: CC] = i_pixel_area_data[(k*NUM_CHANNELS+ch)*CC +: CC];
      end

      conv_channel_mac #(
         .KERNEL            (KERNEL),
         .COLOR_CHANNEL     (COLOR_CHANNEL),
         .DATA_KERNEL_WIDTH (DATA_KERNEL_WIDTH),
         .SHIFT             (SHIFT)
      ) u_mac (
         .i_clk     (i_clk),
         .i_rst_n   (i_rst_n),
         .i_en      (w_advance),
         .i_mode    (r_mode2),
         .i_samples (w_samples),
         .i_coefs   (w_coefs),
         .o_pixel   (o_pixel[ch*CC +: CC])
      );
   end

endmodule

// File: tb/tb_conv_multichannel_pipe.sv
// Scoreboard bench for conv_multichannel_pipe: directed windows push hand-computed
// results into a queue that a negedge monitor pops on every output transfer.
module tb_conv_multichannel_pipe;
   import conv_pkg::*;

   localparam int KK  = 9;
   localparam int NCH = 3;
   localparam int CC  = 8;
   localparam int WW  = KK * NCH * CC;

   typedef struct packed {
      logic [23:0] pix;
      logic [1:0]  user;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_valid = 1'b0;
   logic              o_ready;
   logic [WW-1:0]     i_pixel_area_data = '0;
   logic [1:0]        i_user = 2'b00;
   logic              i_mode = 1'b0;
   logic              i_kernel_wr_en = 1'b0;
   logic [3:0]        i_kernel_wr_addr = 4'd0;
   logic signed [7:0] i_kernel_wr_data = 8'sd0;
   logic              i_kernel_swap = 1'b0;
   logic              o_valid;
   logic              i_ready;
   logic [23:0]       o_pixel;
   logic [1:0]        o_user;

   exp_t        q[$];
   exp_t        mon_e;
   int          errors = 0;
   int          checks = 0;
   int          ready_mode = 0;
   int          ready_idx = 0;
   bit          held_valid = 1'b0;
   logic [23:0] held_pix = '0;
   logic [1:0]  held_user = '0;

   conv_multichannel_pipe #(
      .KERNEL(3), .NUM_CHANNELS(3), .COLOR_CHANNEL(8),
      .DATA_KERNEL_WIDTH(8), .SHIFT(0), .USER_WIDTH(2)
   ) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_valid           (i_valid),
      .o_ready           (o_ready),
      .i_pixel_area_data (i_pixel_area_data),
      .i_user            (i_user),
      .i_mode            (i_mode),
      .i_kernel_wr_en    (i_kernel_wr_en),
      .i_kernel_wr_addr  (i_kernel_wr_addr),
      .i_kernel_wr_data  (i_kernel_wr_data),
      .i_kernel_swap     (i_kernel_swap),
      .o_valid           (o_valid),
      .i_ready           (i_ready),
      .o_pixel           (o_pixel),
      .o_user            (o_user)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   function automatic logic [WW-1:0] mk_win(input logic [23:0] cen, input logic [23:0] nb, input bit rnd);
      logic [WW-1:0] w;
      w = '0;
      for (int k = 0; k < KK; k++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            if (k == 4) w[(k*NCH+ch)*CC +: CC] = cen[ch*CC +: CC];
            else if (rnd) w[(k*NCH+ch)*CC +: CC] = 8'($urandom);
            else w[(k*NCH+ch)*CC +: CC] = nb[ch*CC +: CC];
         end
      end
      return w;
   endfunction

   // Downstream ready: 0 = always ready, 1 = stalled, other = repeating 1,0,0,1.
   initial begin
      i_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: i_ready = 1'b1;
            1: i_ready = 1'b0;
            default: begin
               i_ready = ((ready_idx % 4) == 0) || ((ready_idx % 4) == 3);
               ready_idx++;
            end
         endcase
      end
   end

   // Monitor: handshake rule, stall stability and in-order scoreboard compare.
   always @(negedge clk) begin
      if (rst_n) begin
         check("o_ready_rule", 32'(o_ready), 32'(!o_valid || i_ready));
         if (held_valid && o_valid) begin
            check("stall_pixel_stable", 32'(o_pixel), 32'(held_pix));
            check("stall_user_stable", 32'(o_user), 32'(held_user));
         end
         if (o_valid && i_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got pixel=%h user=%h with empty scoreboard", o_pixel, o_user);
            end else begin
               mon_e = q.pop_front();
               check("out_pixel", 32'(o_pixel), 32'(mon_e.pix));
               check("out_user", 32'(o_user), 32'(mon_e.user));
            end
         end
         held_valid = o_valid && !i_ready;
         held_pix   = o_pixel;
         held_user  = o_user;
      end else begin
         held_valid = 1'b0;
      end
   end

   task automatic send(input logic [WW-1:0] win, input logic [1:0] user, input logic mode,
                       input logic [23:0] exp_pix, input bit push);
      int  n;
      bit  ok;
      i_valid           = 1'b1;
      i_pixel_area_data = win;
      i_user            = user;
      i_mode            = mode;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 40) begin
         @(negedge clk);
         if (o_ready) begin
            ok = 1'b1;
         end else begin
            n++;
            @(posedge clk);
            #1;
         end
      end
      if (ok) begin
         if (push) q.push_back('{pix: exp_pix, user: user});
      end else begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got o_ready=0 for %0d cycles, expected acceptance", n);
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic load_kernel(input coef_t centre, input coef_t other, input bit skip_centre, input bit swap);
      for (int a = 0; a < KK; a++) begin
         if (!(skip_centre && a == 4)) begin
            @(posedge clk);
            #1;
            i_kernel_wr_en   = 1'b1;
            i_kernel_wr_addr = 4'(a);
            i_kernel_wr_data = (a == 4) ? centre : other;
         end
      end
      @(posedge clk);
      #1;
      i_kernel_wr_en = 1'b0;
      i_kernel_swap  = swap;
      @(posedge clk);
      #1;
      i_kernel_swap = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("drain_queue_empty", 32'(q.size()), 32'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      bit found;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_o_valid", 32'(o_valid), 32'd0);
      check("rst_o_pixel", 32'(o_pixel), 32'd0);
      check("rst_o_user", 32'(o_user), 32'd0);
      check("rst_o_ready", 32'(o_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Identity kernel out of reset, with exact latency measurement.
      send(mk_win(24'h5A5A5A, 24'h000000, 1'b1), 2'b01, 1'b0, 24'h5A5A5A, 1'b1);
      lat = 0;
      found = 1'b0;
      for (int c = 1; c <= 8 && !found; c++) begin
         @(negedge clk);
         if (o_valid) begin
            found = 1'b1;
            lat = c;
         end
      end
      check("latency_cycles", 32'(lat), 32'd3);
      drain();

      // Box kernel.
      load_kernel(8'sd1, 8'sd1, 1'b0, 1'b1);
      send(mk_win(24'h202020, 24'h202020, 1'b0), 2'b10, 1'b0, 24'hFFFFFF, 1'b1);
      send(mk_win(24'h101010, 24'h101010, 1'b0), 2'b11, 1'b0, 24'h909090, 1'b1);

      // Laplacian kernel: clip and absolute-value modes, per-channel ordering.
      load_kernel(8'sd8, 8'shFF, 1'b0, 1'b1);
      send(mk_win(24'h000000, 24'h404040, 1'b0), 2'b00, 1'b0, 24'h000000, 1'b1);
      send(mk_win(24'h000000, 24'h404040, 1'b0), 2'b01, 1'b1, 24'hFFFFFF, 1'b1);
      send(mk_win(24'h000000, 24'h040404, 1'b0), 2'b10, 1'b1, 24'h202020, 1'b1);
      send(mk_win(24'h000000, 24'h040201, 1'b0), 2'b11, 1'b1, 24'h201008, 1'b1);
      send(mk_win(24'h202020, 24'h101010, 1'b0), 2'b00, 1'b0, 24'h808080, 1'b1);
      drain();

      // Swap in the accept cycle of A, with the centre write folded into that swap.
      load_kernel(8'sd0, 8'sd1, 1'b1, 1'b0);
      i_kernel_wr_en   = 1'b1;
      i_kernel_wr_addr = 4'd4;
      i_kernel_wr_data = 8'sd1;
      i_kernel_swap    = 1'b1;
      send(mk_win(24'h101010, 24'h101010, 1'b0), 2'b10, 1'b0, 24'h000000, 1'b1);
      i_kernel_wr_en = 1'b0;
      i_kernel_swap  = 1'b0;
      send(mk_win(24'h101010, 24'h101010, 1'b0), 2'b01, 1'b0, 24'h909090, 1'b1);
      drain();

      // Reset with three windows in flight behind a stalled output.
      ready_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         send(mk_win(24'h777777, 24'h333333, 1'b0), 2'(i), 1'b0, 24'h000000, 1'b0);
      end
      @(negedge clk);
      check("inflight_o_valid", 32'(o_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_o_valid", 32'(o_valid), 32'd0);
      check("midrst_o_pixel", 32'(o_pixel), 32'd0);
      check("midrst_o_user", 32'(o_user), 32'd0);
      ready_mode = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      // Back-to-back stream through the restored identity kernel with ready 1,0,0,1.
      ready_mode = 2;
      for (int i = 0; i < 10; i++) begin
         send(mk_win({8'(8'h50 + i), 8'(8'h40 + i), 8'(8'h30 + i)}, 24'h000000, 1'b1),
              2'(i), 1'(i), {8'(8'h50 + i), 8'(8'h40 + i), 8'(8'h30 + i)}, 1'b1);
      end
      ready_mode = 0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
